// File: rtl/sel_filter_pkg.sv
// Shared types and constants for the sel_filter select generator.
package sel_filter_pkg;

  typedef enum logic [1:0] {ST_INIT, ST_STABLE, ST_PENDING} sel_state_t;

  localparam int SEL_STABLE_DEFAULT = 4;
  localparam int SWITCH_CNT_W       = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sel_filter.sv
// Glitch-filtered select generator: f = a ? b : c must hold STABLE_CYCLES samples before sel follows.
module sel_filter
  import sel_filter_pkg::*;
#(
  parameter int STABLE_CYCLES = SEL_STABLE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a,
  input  logic                    b,
  input  logic                    c,
  input  logic                    hold,
  output logic                    sel,
  output logic                    sel_valid,
  output logic                    sel_changed,
  output logic [SWITCH_CNT_W-1:0] switch_count
);

  localparam int                 CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_COMMIT = CNT_W'(STABLE_CYCLES);

  sel_state_t       state_q, state_d;
  logic             raw_q, raw_d;
  logic             cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;

  assign raw_d = a ? b : c;

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    changed_d = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        // First commit is silent: it establishes sel rather than toggling it.
        if (cnt_q == CNT_COMMIT) begin
          sel_d   = cand_q;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (raw_q == cand_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cand_d = raw_q;
          cnt_d  = CNT_W'(1);
        end
      end

      ST_STABLE: begin
        if (!hold && (raw_q != sel_q)) begin
          cand_d  = raw_q;
          cnt_d   = CNT_W'(1);
          state_d = ST_PENDING;
        end
      end

      ST_PENDING: begin
        // hold and bounce-back both outrank the commit on the same edge.
        if (hold || (raw_q == sel_q)) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_COMMIT) begin
          sel_d     = cand_q;
          changed_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      raw_q     <= 1'b0;
      cand_q    <= 1'b0;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      raw_q     <= raw_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  sat_counter #(
    .W (SWITCH_CNT_W)
  ) u_switch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (changed_d),
    .count (switch_count)
  );

  assign sel         = sel_q;
  assign sel_valid   = valid_q;
  assign sel_changed = changed_q;

endmodule
